// File: rtl/protobuf_pkg.sv
// Shared protobuf streaming definitions.
// Purpose: the varint geometry constants, the wire-byte count type and the
//          serializer state encoding, used by the varint stream blocks.
// Contents:
//   VARINT_DECODE_SIZE  - width of an unencoded varint integer (64)
//   VARINT_ENCODE_BYTES - maximum wire bytes of one encoded varint (10)
//   varint_size_t       - wire byte count, 1..VARINT_ENCODE_BYTES when legal
//   ser_state_e         - byte serializer states
package protobuf_pkg;

    localparam int VARINT_DECODE_SIZE  = 64;
    localparam int VARINT_ENCODE_BYTES = 10;

    typedef logic [3:0] varint_size_t;

    typedef enum logic {
        SER_IDLE = 1'b0,
        SER_SEND = 1'b1
    } ser_state_e;

endpackage

// File: rtl/varint_byte_serializer.sv
// Varint byte serializer.
// Purpose: accepts one packed encoded varint word with its wire byte count
//          and streams it out one byte per cycle, first wire byte first.
//          Back-to-back words run without an idle cycle; words with an
//          illegal byte count are dropped and flagged on err_size.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   in_valid/in_ready   - word handshake
//   in_data             - packed word, wire byte k in in_data[ENCODE_SIZE-1-8k -: 8]
//   in_size             - number of wire bytes, legal 1..ENCODE_BYTES
//   out_valid/out_ready - byte handshake
//   out_data, out_last  - current byte, final byte of the word
//   err_size            - one-cycle pulse when an illegal word is dropped
//   word_count          - words fully emitted, wraps at 2^16
module varint_byte_serializer
    import protobuf_pkg::*;
#(
    parameter int DECODE_SIZE = VARINT_DECODE_SIZE,
    parameter int ENCODE_SIZE = ((DECODE_SIZE - 1) / 7 + 1) * 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [ENCODE_SIZE-1:0] in_data,
    input  logic [3:0]             in_size,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [7:0]             out_data,
    output logic                   out_last,
    output logic                   err_size,
    output logic [15:0]            word_count
);

    localparam int ENCODE_BYTES = ENCODE_SIZE / 8;

    ser_state_e             state_q;
    logic [ENCODE_SIZE-1:0] hold_q;
    varint_size_t           size_q;
    varint_size_t           idx_q;
    logic                   err_size_q;
    logic [15:0]            word_count_q;
    logic [15:0]            word_count_d;

    logic       send;
    logic       last_byte;
    logic       last_hs;
    logic       accept;
    logic       size_legal;
    logic [7:0] hold_bytes [ENCODE_BYTES];

    // Wire byte view of the holding register: entry k is the k-th byte sent.
    genvar gi;
    generate
        for (gi = 0; gi < ENCODE_BYTES; gi++) begin : g_bytes
            assign hold_bytes[gi] = hold_q[ENCODE_SIZE-1-8*gi -: 8];
        end
    endgenerate

    assign send       = (state_q == SER_SEND);
    assign last_byte  = send && (idx_q == size_q - 4'd1);
    assign last_hs    = last_byte && out_ready;
    // A new word may enter while idle or on the handshake that retires the
    // final byte of the current word; this keeps the byte stream gap-free.
    assign in_ready   = !send || last_hs;
    assign accept     = in_valid && in_ready;
    assign size_legal = (in_size != 4'd0) && (in_size <= varint_size_t'(ENCODE_BYTES));
    assign word_count_d = word_count_q + 16'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= SER_IDLE;
            hold_q       <= '0;
            size_q       <= '0;
            idx_q        <= '0;
            err_size_q   <= 1'b0;
            word_count_q <= '0;
        end else begin
            err_size_q <= accept && !size_legal;
            case (state_q)
                SER_IDLE: begin
                    if (accept && size_legal) begin
                        hold_q  <= in_data;
                        size_q  <= in_size;
                        idx_q   <= '0;
                        state_q <= SER_SEND;
                    end
                end
                SER_SEND: begin
                    if (out_ready) begin
                        if (last_byte) begin
                            word_count_q <= word_count_d;
                            idx_q        <= '0;
                            if (accept && size_legal) begin
                                hold_q <= in_data;
                                size_q <= in_size;
                            end else begin
                                state_q <= SER_IDLE;
                            end
                        end else begin
                            idx_q <= idx_q + 4'd1;
                        end
                    end
                end
                default: state_q <= SER_IDLE;
            endcase
        end
    end

    assign out_valid  = send;
    assign out_data   = hold_bytes[idx_q];
    assign out_last   = last_byte;
    assign err_size   = err_size_q;
    assign word_count = word_count_q;

endmodule

// File: tb/tb_varint_byte_serializer.sv
module tb_varint_byte_serializer;

    localparam int ES = 80;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [ES-1:0] in_data = '0;
    logic [3:0]    in_size = 4'd0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [7:0]    out_data;
    logic          out_last;
    logic          err_size;
    logic [15:0]   word_count;

    int checks = 0;
    int failures = 0;

    // Scoreboard entries: {last, data}
    logic [8:0] sb [$];

    varint_byte_serializer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_size   (in_size),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .err_size  (err_size),
        .word_count(word_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive a word and push its expected bytes (wire byte k from the top).
    task automatic drive_word(input logic [ES-1:0] data, input logic [3:0] size);
        in_valid = 1'b1;
        in_data  = data;
        in_size  = size;
        for (int k = 0; k < int'(size); k++)
            sb.push_back({(k == int'(size) - 1), data[ES-1-8*k -: 8]});
    endtask

    // One clock: compare any byte handshake against the scoreboard at the
    // falling edge, then return 1 time unit after the next rising edge.
    task automatic cycle();
        logic [9:0] exp;
        @(negedge clk);
        if (out_valid && out_ready) begin
            exp = (sb.size() > 0) ? {1'b1, sb.pop_front()} : 10'h000;
            chk("byte", {22'd0, 1'b1, out_last, out_data}, {22'd0, exp});
            $display("byte data=%02h last=%0d", out_data, out_last);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [ES-1:0] w;
        logic [7:0]    prev_data;
        logic          prev_rdy;
        int            k;

        // ---------------- reset ----------------
        #2;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", {24'd0, out_data}, 32'd0);
        chk("rst_out_last", {31'd0, out_last}, 32'd0);
        chk("rst_err", {31'd0, err_size}, 32'd0);
        chk("rst_wc", {16'd0, word_count}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;

        // ---------------- value 300 ----------------
        out_ready = 1'b1;
        drive_word({8'hAC, 8'h02, 64'd0}, 4'd2);
        cycle();
        in_valid = 1'b0;
        chk("t1_b0_valid", {31'd0, out_valid}, 32'd1);
        chk("t1_b0_data", {24'd0, out_data}, 32'hAC);
        chk("t1_b0_last", {31'd0, out_last}, 32'd0);
        chk("t1_b0_in_ready", {31'd0, in_ready}, 32'd0);
        cycle();
        chk("t1_b1_data", {24'd0, out_data}, 32'h02);
        chk("t1_b1_last", {31'd0, out_last}, 32'd1);
        chk("t1_b1_in_ready", {31'd0, in_ready}, 32'd1);
        cycle();
        chk("t1_idle", {31'd0, out_valid}, 32'd0);
        chk("t1_wc", {16'd0, word_count}, 32'd1);

        // ---------------- back-to-back ----------------
        drive_word({8'h05, 72'd0}, 4'd1);
        cycle();
        chk("t2_05_data", {24'd0, out_data}, 32'h05);
        chk("t2_05_last", {31'd0, out_last}, 32'd1);
        chk("t2_05_in_ready", {31'd0, in_ready}, 32'd1);
        drive_word({8'hFF, 8'hFF, 8'h03, 56'd0}, 4'd3);
        cycle();
        in_valid = 1'b0;
        chk("t2_b0_valid", {31'd0, out_valid}, 32'd1);
        chk("t2_b0_data", {24'd0, out_data}, 32'hFF);
        cycle();
        chk("t2_b1_valid", {31'd0, out_valid}, 32'd1);
        cycle();
        chk("t2_b2_data", {24'd0, out_data}, 32'h03);
        chk("t2_b2_last", {31'd0, out_last}, 32'd1);
        cycle();
        chk("t2_idle", {31'd0, out_valid}, 32'd0);
        chk("t2_wc", {16'd0, word_count}, 32'd3);

        // ---------------- size 10 with backpressure ----------------
        w = {{9{8'hFF}}, 8'h01};
        drive_word(w, 4'd10);
        cycle();
        in_valid = 1'b0;
        k = 0;
        prev_rdy = 1'b1;
        prev_data = 8'h00;
        while (sb.size() > 0 && k < 60) begin
            out_ready = (k % 3 == 0);
            if (!prev_rdy) begin
                chk("t3_stall_data", {24'd0, out_data}, {24'd0, prev_data});
                chk("t3_stall_valid", {31'd0, out_valid}, 32'd1);
            end
            #1;
            chk("t3_in_ready", {31'd0, in_ready}, {31'd0, out_ready && (sb.size() == 1)});
            prev_data = out_data;
            prev_rdy  = out_ready;
            cycle();
            k++;
        end
        chk("t3_drained", sb.size(), 32'd0);
        out_ready = 1'b1;
        cycle();
        chk("t3_idle", {31'd0, out_valid}, 32'd0);
        chk("t3_wc", {16'd0, word_count}, 32'd4);

        // ---------------- illegal sizes ----------------
        drive_word({8'h11, 72'd0}, 4'd0);
        cycle();
        in_valid = 1'b0;
        chk("t4_s0_err", {31'd0, err_size}, 32'd1);
        chk("t4_s0_valid", {31'd0, out_valid}, 32'd0);
        cycle();
        chk("t4_s0_err_clr", {31'd0, err_size}, 32'd0);
        in_valid = 1'b1;
        in_data  = {8'h22, 72'd0};
        in_size  = 4'd11;
        cycle();
        in_valid = 1'b0;
        chk("t4_s11_err", {31'd0, err_size}, 32'd1);
        chk("t4_s11_valid", {31'd0, out_valid}, 32'd0);
        cycle();
        chk("t4_s11_err_clr", {31'd0, err_size}, 32'd0);
        chk("t4_wc", {16'd0, word_count}, 32'd4);

        // Illegal word arriving on the last-byte handshake
        drive_word({8'h33, 72'd0}, 4'd1);
        cycle();
        in_valid = 1'b1;
        in_data  = {8'h44, 72'd0};
        in_size  = 4'd0;
        cycle();
        in_valid = 1'b0;
        chk("t4b_err", {31'd0, err_size}, 32'd1);
        chk("t4b_idle", {31'd0, out_valid}, 32'd0);
        chk("t4b_wc", {16'd0, word_count}, 32'd5);

        // ---------------- reset mid-word ----------------
        drive_word({8'h81, 8'h82, 8'h83, 8'h84, 8'h05, 40'd0}, 4'd5);
        cycle();
        in_valid = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("t5_rst_last", {31'd0, out_last}, 32'd0);
        chk("t5_rst_data", {24'd0, out_data}, 32'd0);
        chk("t5_rst_wc", {16'd0, word_count}, 32'd0);
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        drive_word({8'h7F, 72'd0}, 4'd1);
        cycle();
        in_valid = 1'b0;
        chk("t5_7f_data", {24'd0, out_data}, 32'h7F);
        chk("t5_7f_last", {31'd0, out_last}, 32'd1);
        cycle();
        chk("t5_idle", {31'd0, out_valid}, 32'd0);
        chk("t5_wc", {16'd0, word_count}, 32'd1);

        // ---------------- word_count wrap ----------------
        for (int i = 0; i < 65534; i++) begin
            drive_word({8'(i), 72'd0}, 4'd1);
            cycle();
        end
        in_valid = 1'b0;
        cycle();
        chk("t6_wc_max", {16'd0, word_count}, 32'h0000FFFF);
        drive_word({8'h01, 72'd0}, 4'd1);
        cycle();
        in_valid = 1'b0;
        cycle();
        chk("t6_wc_wrap", {16'd0, word_count}, 32'd0);
        chk("t6_sb_empty", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/varint_byte_serializer.md
Name: varint_byte_serializer

Overview:
- Downstream neighbour of the varint encoder.
- Accepts one packed, encoded varint word plus its byte count, and streams it out one byte per cycle on a valid/ready byte interface.
- Feeds the protobuf output byte stream, field framer and DMA packer.
- Supports back-to-back words with no idle cycle, full backpressure, and rejection of illegal sizes.

Parameters:
- DECODE_SIZE, 64, width of the original unencoded integer.
- ENCODE_SIZE, ((DECODE_SIZE-1)/7+1)*8 (80), width of the packed encoded word.
- ENCODE_BYTES, ENCODE_SIZE/8 (10), maximum bytes per word. Localparam, derived.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  encoded word present.
- in_ready  out  1  word accepted when in_valid && in_ready.
- in_data  in  ENCODE_SIZE  packed encoded word. Wire byte k = in_data[ENCODE_SIZE-1-8k -: 8], so the first wire byte is in the top byte.
- in_size  in  4  number of valid wire bytes; legal range 1..ENCODE_BYTES.
- out_valid  out  1  byte present.
- out_ready  in  1  downstream accepts the byte.
- out_data  out  8  current byte.
- out_last  out  1  final byte of the current word; qualified by out_valid.
- err_size  out  1  one-cycle pulse when a word with an illegal size is dropped.
- word_count  out  16  count of words fully emitted; wraps at 2^16.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE.
  - out_valid=0, out_data=0, out_last=0.
  - err_size=0, word_count=0, internal byte index=0, holding register=0.
  - in_ready=1 once reset is deasserted.
- State machine:
  - IDLE: out_valid=0, in_ready=1.
    - Legal accept: latch in_data into the holding register, latch in_size, idx=0, go to SEND.
    - Illegal accept (in_size==0 or in_size>ENCODE_BYTES): pulse err_size next cycle, stay in IDLE, emit no bytes.
  - SEND:
    - out_valid=1.
    - out_data = holding byte idx.
    - out_last = (idx==size-1).
    - On out_valid&&out_ready with !out_last: idx++.
    - On out_valid&&out_ready with out_last: word_count++. Then:
      - if a legal word is accepted in the same cycle: reload, idx=0, stay in SEND;
      - otherwise go to IDLE.
- in_ready = (state==IDLE) || (out_valid && out_ready && out_last). This is combinational from out_ready; there is no combinational path from in_valid to out_*.
- Latency: a word accepted in cycle T presents byte 0 in cycle T+1. A size-N word takes N handshake cycles. Back-to-back words run at 100% byte throughput.
- Backpressure: while out_ready=0, out_data, out_last and idx hold stable, and out_valid never deasserts mid-word.
- Illegal word arriving on the last-byte handshake cycle:
  - the current word completes normally;
  - the illegal word is dropped and err_size pulses;
  - next state is IDLE.
- Holding-register bytes at idx >= size are don't-care and never emitted. Continuation bits (bit 7) are not checked or modified.
- word_count wraps 0xFFFF -> 0x0000 without flag.
- Reset asserted mid-word aborts the word immediately. The remaining bytes are never emitted and all outputs return to reset values.

Decomposition:
- Shared package protobuf_pkg:
  - VARINT_DECODE_SIZE=64, VARINT_ENCODE_BYTES=10;
  - typedef varint_size_t (logic[3:0]);
  - typedef enum ser_state_e {SER_IDLE, SER_SEND}.
- No sub-module is needed. The byte mux (holding register indexed by idx) is inline.

Test Plan:
- Value 300, encoded as in_data top bytes 0xAC,0x02, in_size=2, out_ready=1 -> out_data 0xAC (last=0) at T+1, 0x02 (last=1) at T+2, word_count=1, in_ready=1 at T+2.
- Two back-to-back words, size 1 (0x05) then size 3 (0xFF,0xFF,0x03), in_valid held high -> bytes 05,FF,FF,03 on 4 consecutive cycles, last on the 05 and 03 bytes, word_count=2.
- Size-10 word (max uint64: nine 0xFF, then 0x01) with out_ready toggled 1,0,0,1,... -> all 10 bytes emitted in order, out_data stable while stalled, in_ready=0 until the final handshake.
- in_size=0, then in_size=11 -> no out_valid, err_size pulses once per word, word_count unchanged.
- Reset asserted after byte 2 of a size-5 word -> out_valid=0 immediately; after release the next size-1 word (0x7F) emits only 0x7F with last=1.
- Preload of 0xFFFF completed words, then one more word -> word_count=0x0000.
